clk_lock_monitor: RTL and testbench
===================================

Name: clk_lock_monitor

Overview:
Fabric-side frequency and lock checker for the clocks produced by the MSS clock conditioning circuit. That circuit drives its fabric lock output to a constant 0, so this block supplies the lock indication instead. It samples a monitored clock, MON_CLK, as data in the FAB_CLK domain and counts MON_CLK rising edges over fixed windows of FAB_CLK cycles. After LOCK_COUNT consecutive in-tolerance windows it asserts LOCK, and it drops LOCK on the first bad window.

Parameters:
CNT_W, 16, width of the window and edge counters and of FREQ_COUNT
WINDOW_CYCLES, 1000, FAB_CLK cycles per measurement window (2..2^CNT_W-1)
EXP_EDGES, 250, expected MON_CLK rising edges per window
TOL, 2, allowed deviation from EXP_EDGES (inclusive)
LOCK_COUNT, 4, consecutive good windows required for LOCK (1..15)

Ports:
FAB_CLK  input  1  sole clock
M2F_RESET_N  input  1  synchronous active-low reset
ENABLE  input  1  1 = measure; 0 = return to IDLE
MON_CLK  input  1  asynchronous monitored clock, frequency < FAB_CLK/2
LOCK  output  1  frequency verified stable
FREQ_COUNT  output  CNT_W  edge count of the last completed window
COUNT_VALID  output  1  one-cycle pulse when FREQ_COUNT updates
ERR_HIGH  output  1  last window count > EXP_EDGES+TOL
ERR_LOW  output  1  last window count < EXP_EDGES-TOL (includes dead clock)

Behaviour:
- Reset (M2F_RESET_N=0 at a FAB_CLK edge):
  - all outputs 0, synchronizer flops 0, counters 0, good_cnt 0, state IDLE.
  - Reset has priority over every other event, including a window end in progress.
- MON_CLK input path:
  - 2-flop synchronizer, then a third flop for edge detect.
  - edge_pulse = sync2 & ~sync3.
  - Latency from a MON_CLK rise to edge_pulse: 2-3 FAB_CLK cycles.
- States: IDLE, MEASURE.
- IDLE:
  - counters held at 0, good_cnt 0, LOCK 0.
  - FREQ_COUNT, ERR_HIGH and ERR_LOW hold their last values.
  - ENABLE=1 moves to MEASURE on the next edge.
- MEASURE:
  - win_cnt increments each cycle.
  - edge_cnt increments on edge_pulse and saturates at 2^CNT_W-1 (no wrap).
- Window end (win_cnt == WINDOW_CYCLES-1):
  - An edge_pulse on this cycle is counted in the closing window.
  - On the next edge, FREQ_COUNT takes the final count and COUNT_VALID pulses for 1 cycle.
  - ERR_HIGH and ERR_LOW are updated; they are mutually exclusive.
  - win_cnt and edge_cnt restart at 0; the next window's counting starts on that cycle.
- Evaluation at window end:
  - In-tolerance window: good_cnt saturating-increments to LOCK_COUNT. LOCK=1 in the same cycle that good_cnt reaches LOCK_COUNT (registered together with COUNT_VALID).
  - Bad window: good_cnt=0 and LOCK=0 in the same cycle as COUNT_VALID.
- Tolerance bounds:
  - Computed in CNT_W+1 bits.
  - EXP_EDGES-TOL clamps at 0.
  - EXP_EDGES+TOL clamps at 2^CNT_W-1.
- ENABLE deasserted mid-window:
  - next state IDLE; partial window discarded; no COUNT_VALID.
  - LOCK=0 and good_cnt=0 on the next edge.
- ENABLE=0 on a window-end cycle: the deassertion wins; that window is not reported.
- Throughput: one result per WINDOW_CYCLES cycles, with no dead cycles between windows.

Decomposition:
- Shared package clk_mon_pkg holds:
  - state enum: IDLE, MEASURE
  - function computing the clamped lo/hi bounds from EXP_EDGES, TOL and CNT_W
- One sub-module, clk_edge_sync: 2-flop synchronizer plus rising-edge detect, reset synchronously to 0. It is reusable for other async status inputs.
- Window counter, edge counter and evaluation logic stay in the top module.

Test Plan:
1. Nominal lock.
   - Setup: WINDOW_CYCLES=100, EXP_EDGES=25, TOL=1, LOCK_COUNT=3; MON_CLK period = 4 FAB_CLK; ENABLE=1.
   - Expected: COUNT_VALID every 100 cycles with FREQ_COUNT=25, 25 or 26 allowed (phase); ERR_HIGH=ERR_LOW=0; LOCK rises with the 3rd COUNT_VALID.
2. Lost lock.
   - Setup: after LOCK, change MON_CLK period to 5 FAB_CLK (20 edges).
   - Expected: the first window with FREQ_COUNT≤23 gives ERR_LOW=1 and LOCK=0 with the same COUNT_VALID. Restoring period 4 needs 3 more good windows before LOCK=1.
3. Dead and fast clock.
   - Setup A: MON_CLK held at 0. Expected: FREQ_COUNT=0, ERR_LOW=1, LOCK never asserts.
   - Setup B: MON_CLK period 2. Expected: FREQ_COUNT=50, ERR_HIGH=1.
4. Boundary edge.
   - Setup: place a synchronized edge_pulse exactly on the win_cnt=99 cycle.
   - Expected: it is counted in the closing window (FREQ_COUNT one higher than with the pulse one cycle later).
5. ENABLE drop mid-window.
   - Setup: with LOCK=1, deassert ENABLE at win_cnt=50.
   - Expected: no COUNT_VALID; LOCK=0 next cycle; FREQ_COUNT holds 25. On re-enable, the first report comes 100 cycles later.
6. Reset mid-operation.
   - Setup: M2F_RESET_N=0 for 1 cycle during MEASURE with LOCK=1.
   - Expected: all outputs 0 next cycle. The first COUNT_VALID after release comes at least 101 cycles later (IDLE→MEASURE plus a full window).

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the fabric-side clock lock monitor.
package clk_mon_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } mon_state_t;

    typedef struct packed {
        logic [32:0] lo;
        logic [32:0] hi;
    } bounds_t;

    // Tolerance bounds clamped to [0, 2^cnt_w-1] so a wide TOL can never wrap.
    function automatic bounds_t calc_bounds(input int unsigned exp_edges,
                                            input int unsigned tol,
                                            input int unsigned cnt_w);
        logic [32:0] max_cnt;
        logic [32:0] e;
        logic [32:0] t;
        logic [32:0] sum;
        bounds_t     b;
        max_cnt = (33'd1 << cnt_w) - 33'd1;
        e       = {1'b0, exp_edges};
        t       = {1'b0, tol};
        sum     = e + t;
        b.lo    = (e >= t) ? (e - t) : 33'd0;
        b.lo    = (b.lo > max_cnt) ? max_cnt : b.lo;
        b.hi    = (sum > max_cnt) ? max_cnt : sum;
        return b;
    endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect for an asynchronous status input.
module clk_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    // NOTE: non-blocking assignments make each stage take the previous stage's old value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/clk_lock_monitor.sv
// Counts MON_CLK rising edges over fixed FAB_CLK windows and derives a LOCK
// indication after LOCK_COUNT consecutive in-tolerance windows.
module clk_lock_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned EXP_EDGES     = 250,
    parameter int unsigned TOL           = 2,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input  logic             FAB_CLK,
    input  logic             M2F_RESET_N,
    input  logic             ENABLE,
    input  logic             MON_CLK,
    output logic             LOCK,
    output logic [CNT_W-1:0] FREQ_COUNT,
    output logic             COUNT_VALID,
    output logic             ERR_HIGH,
    output logic             ERR_LOW
);

    localparam bounds_t          BOUNDS   = calc_bounds(EXP_EDGES, TOL, CNT_W);
    localparam logic [CNT_W:0]   LO_BOUND = BOUNDS.lo[CNT_W:0];
    localparam logic [CNT_W:0]   HI_BOUND = BOUNDS.hi[CNT_W:0];
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

    mon_state_t       r_state;
    mon_state_t       w_state_next;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] w_edge_next;
    logic [CNT_W:0]   w_final_ext;
    logic [3:0]       r_good_cnt;
    logic [3:0]       w_good_next;
    logic             r_lock;
    logic             r_count_valid;
    logic             r_err_high;
    logic             r_err_low;
    logic [CNT_W-1:0] r_freq_count;
    logic             w_edge_pulse;
    logic             w_measuring;
    logic             w_win_end;
    logic             w_in_tol;

    clk_edge_sync u_mon_sync (
        .i_clk   (FAB_CLK),
        .i_rst_n (M2F_RESET_N),
        .i_async (MON_CLK),
        .o_rise  (w_edge_pulse)
    );

    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) r_state <= IDLE;
        else              r_state <= w_state_next;
    end

    // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ENABLE)  w_state_next = MEASURE;
            MEASURE: if (!ENABLE) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A deasserted ENABLE wins over a window end: that window is never reported.
    assign w_measuring = (r_state == MEASURE) && ENABLE;
    assign w_win_end   = w_measuring && (r_win_cnt == WIN_LAST);
    assign w_edge_next = (w_edge_pulse && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + 1'b1 : r_edge_cnt;
    assign w_final_ext = {1'b0, w_edge_next};
    assign w_in_tol    = (w_final_ext >= LO_BOUND) && (w_final_ext <= HI_BOUND);
    assign w_good_next = (r_good_cnt >= LOCK_TGT) ? LOCK_TGT : r_good_cnt + 1'b1;

    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            r_win_cnt     <= '0;
            r_edge_cnt    <= '0;
            r_good_cnt    <= '0;
            r_lock        <= 1'b0;
            r_count_valid <= 1'b0;
            r_err_high    <= 1'b0;
            r_err_low     <= 1'b0;
            r_freq_count  <= '0;
        end else begin
            r_count_valid <= 1'b0;
            if (!w_measuring) begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
                r_good_cnt <= '0;
                r_lock     <= 1'b0;
            end else if (w_win_end) begin
                // The pulse on the closing cycle is folded into the reported count.
                r_win_cnt     <= '0;
                r_edge_cnt    <= '0;
                r_freq_count  <= w_edge_next;
                r_count_valid <= 1'b1;
                r_err_high    <= (w_final_ext > HI_BOUND);
                r_err_low     <= (w_final_ext < LO_BOUND);
                if (w_in_tol) begin
                    r_good_cnt <= w_good_next;
                    r_lock     <= (w_good_next == LOCK_TGT);
                end else begin
                    r_good_cnt <= '0;
                    r_lock     <= 1'b0;
                end
            end else begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_edge_cnt <= w_edge_next;
            end
        end
    end

    assign LOCK        = r_lock;
    assign FREQ_COUNT  = r_freq_count;
    assign COUNT_VALID = r_count_valid;
    assign ERR_HIGH    = r_err_high;
    assign ERR_LOW     = r_err_low;

endmodule

// File: tb/tb_clk_lock_monitor.sv
// Directed bench for clk_lock_monitor: window 100, expect 25 +/- 1, lock after 3.
module tb_clk_lock_monitor;

    localparam int CNT_W = 16;

    logic             FAB_CLK = 1'b0;
    logic             M2F_RESET_N;
    logic             ENABLE;
    logic             MON_CLK;
    logic             LOCK;
    logic [CNT_W-1:0] FREQ_COUNT;
    logic             COUNT_VALID;
    logic             ERR_HIGH;
    logic             ERR_LOW;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitored-clock generator requests (written by the stimulus thread only).
    int req_period = 4;
    int req_seq    = 0;
    bit mon_level  = 1'b0;
    // Generator state (written by the generator only). Period 0 = follow mon_level.
    int mon_period = 4;
    int mon_phase  = 0;
    int seen_seq   = 0;

    clk_lock_monitor #(
        .CNT_W         (CNT_W),
        .WINDOW_CYCLES (100),
        .EXP_EDGES     (25),
        .TOL           (1),
        .LOCK_COUNT    (3)
    ) dut (
        .FAB_CLK     (FAB_CLK),
        .M2F_RESET_N (M2F_RESET_N),
        .ENABLE      (ENABLE),
        .MON_CLK     (MON_CLK),
        .LOCK        (LOCK),
        .FREQ_COUNT  (FREQ_COUNT),
        .COUNT_VALID (COUNT_VALID),
        .ERR_HIGH    (ERR_HIGH),
        .ERR_LOW     (ERR_LOW)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    // MON_CLK is phase-locked to FAB_CLK, so a steady period p gives exactly 100/p edges per window.
    always @(negedge FAB_CLK) begin
        if (seen_seq != req_seq) begin
            mon_period = req_period;
            mon_phase  = 0;
            seen_seq   = req_seq;
        end
        if (mon_period == 0) begin
            MON_CLK = mon_level;
        end else begin
            MON_CLK   = (mon_phase < mon_period / 2);
            mon_phase = (mon_phase + 1) % mon_period;
        end
    end

    task automatic set_mon(input int p);
        req_period = p;
        req_seq++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge FAB_CLK);
            #1;
        end
    endtask

    // Waits for the next COUNT_VALID; n = edges consumed, ok = 0 on timeout.
    task automatic wait_valid(input int max_cyc, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < max_cyc) begin
            @(posedge FAB_CLK);
            #1;
            n++;
            if (COUNT_VALID) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        M2F_RESET_N = 1'b0;
        ENABLE      = 1'b0;
        tick(3);
        n_tests++;
        if ({LOCK, COUNT_VALID, ERR_HIGH, ERR_LOW, FREQ_COUNT} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got lock=%b cv=%b eh=%b el=%b freq=%0d, expected all 0",
                     LOCK, COUNT_VALID, ERR_HIGH, ERR_LOW, FREQ_COUNT);
        end
        M2F_RESET_N = 1'b1;
        tick(5);
        n_tests++;
        if ({LOCK, COUNT_VALID} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_quiet: got lock=%b cv=%b, expected 0 0", LOCK, COUNT_VALID);
        end
    endtask

    task automatic test_nominal();
        int n;
        bit ok;
        ENABLE = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            wait_valid(150, n, ok);
            n_tests++;
            // First report: one IDLE->MEASURE edge plus a 100-cycle window.
            if (!ok || n != ((r == 1) ? 101 : 100)) begin
                n_fail++;
                $display("FAIL nominal_spacing[%0d]: got %0d cycles (ok=%b), expected %0d",
                         r, n, ok, (r == 1) ? 101 : 100);
            end
            n_tests++;
            if ({FREQ_COUNT, ERR_HIGH, ERR_LOW, LOCK} !== {16'd25, 1'b0, 1'b0, (r == 3)}) begin
                n_fail++;
                $display("FAIL nominal_report[%0d]: got freq=%0d eh=%b el=%b lock=%b, expected 25 0 0 %b",
                         r, FREQ_COUNT, ERR_HIGH, ERR_LOW, LOCK, (r == 3));
            end
        end
        tick(1);
        n_tests++;
        if (COUNT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse_width: got cv=%b one cycle later, expected 0", COUNT_VALID);
        end
    endtask

    task automatic test_lost_lock();
        int n;
        bit ok;
        int cnt;
        bit exp_low;
        bit exp_high;
        int good;
        set_mon(5);
        // Transition window mixes both periods; flags must still follow the count.
        wait_valid(150, n, ok);
        cnt      = int'(FREQ_COUNT);
        exp_low  = (cnt < 24);
        exp_high = (cnt > 26);
        n_tests++;
        if (!ok || cnt < 20 || cnt > 25 ||
            {ERR_LOW, ERR_HIGH, LOCK} !== {exp_low, exp_high, !(exp_low || exp_high)}) begin
            n_fail++;
            $display("FAIL lost_transition: got ok=%b freq=%0d el=%b eh=%b lock=%b, expected 20..25 %b %b %b",
                     ok, cnt, ERR_LOW, ERR_HIGH, LOCK, exp_low, exp_high, !(exp_low || exp_high));
        end
        wait_valid(150, n, ok);
        n_tests++;
        if (!ok || {FREQ_COUNT, ERR_LOW, ERR_HIGH, LOCK} !== {16'd20, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL lost_slow: got ok=%b freq=%0d el=%b eh=%b lock=%b, expected 20 1 0 0",
                     ok, FREQ_COUNT, ERR_LOW, ERR_HIGH, LOCK);
        end
        set_mon(4);
        wait_valid(150, n, ok);
        good = (FREQ_COUNT >= 16'd24 && FREQ_COUNT <= 16'd26) ? 1 : 0;
        n_tests++;
        if (!ok || LOCK !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_transition: got ok=%b lock=%b, expected lock 0", ok, LOCK);
        end
        while (good < 3) begin
            wait_valid(150, n, ok);
            good++;
            n_tests++;
            if (!ok || {FREQ_COUNT, ERR_HIGH, ERR_LOW, LOCK} !== {16'd25, 1'b0, 1'b0, (good == 3)}) begin
                n_fail++;
                $display("FAIL relock_good[%0d]: got ok=%b freq=%0d eh=%b el=%b lock=%b, expected 25 0 0 %b",
                         good, ok, FREQ_COUNT, ERR_HIGH, ERR_LOW, LOCK, (good == 3));
            end
        end
    endtask

    task automatic test_dead_and_fast();
        int n;
        bit ok;
        mon_level = 1'b0;
        set_mon(0);
        wait_valid(150, n, ok);
        for (int r = 0; r < 3; r++) begin
            wait_valid(150, n, ok);
            n_tests++;
            if (!ok || {FREQ_COUNT, ERR_LOW, ERR_HIGH, LOCK} !== {16'd0, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL dead_clock[%0d]: got ok=%b freq=%0d el=%b eh=%b lock=%b, expected 0 1 0 0",
                         r, ok, FREQ_COUNT, ERR_LOW, ERR_HIGH, LOCK);
            end
        end
        set_mon(2);
        wait_valid(150, n, ok);
        for (int r = 0; r < 2; r++) begin
            wait_valid(150, n, ok);
            n_tests++;
            if (!ok || {FREQ_COUNT, ERR_LOW, ERR_HIGH, LOCK} !== {16'd50, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL fast_clock[%0d]: got ok=%b freq=%0d el=%b eh=%b lock=%b, expected 50 0 1 0",
                         r, ok, FREQ_COUNT, ERR_LOW, ERR_HIGH, LOCK);
            end
        end
    endtask

    // A rise driven 97 cycles after a report yields edge_pulse during win_cnt=99.
    task automatic test_boundary_edge();
        int n;
        bit ok;
        mon_level = 1'b0;
        set_mon(0);
        wait_valid(150, n, ok);
        tick(97);
        mon_level = 1'b1;
        wait_valid(150, n, ok);
        mon_level = 1'b0;
        n_tests++;
        if (!ok || {FREQ_COUNT, ERR_LOW} !== {16'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL boundary_on_last: got ok=%b freq=%0d el=%b, expected 1 1", ok, FREQ_COUNT, ERR_LOW);
        end
        tick(98);
        mon_level = 1'b1;
        wait_valid(150, n, ok);
        mon_level = 1'b0;
        n_tests++;
        if (!ok || FREQ_COUNT !== 16'd0) begin
            n_fail++;
            $display("FAIL boundary_one_late: got ok=%b freq=%0d, expected 0", ok, FREQ_COUNT);
        end
        wait_valid(150, n, ok);
        n_tests++;
        if (!ok || FREQ_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL boundary_next_window: got ok=%b freq=%0d, expected 1", ok, FREQ_COUNT);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        bit ok;
        bit locked;
        bit seen_valid;
        set_mon(4);
        locked = 1'b0;
        for (int k = 0; k < 6 && !locked; k++) begin
            wait_valid(150, n, ok);
            if (ok && LOCK) locked = 1'b1;
        end
        n_tests++;
        if (!locked) begin
            n_fail++;
            $display("FAIL drop_prelock: got lock=%b, expected 1", LOCK);
        end
        tick(50);
        ENABLE = 1'b0;
        tick(1);
        n_tests++;
        if ({LOCK, COUNT_VALID, FREQ_COUNT} !== {1'b0, 1'b0, 16'd25}) begin
            n_fail++;
            $display("FAIL drop_next_cycle: got lock=%b cv=%b freq=%0d, expected 0 0 25",
                     LOCK, COUNT_VALID, FREQ_COUNT);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (COUNT_VALID) seen_valid = 1'b1;
        end
        n_tests++;
        if (seen_valid || FREQ_COUNT !== 16'd25) begin
            n_fail++;
            $display("FAIL drop_no_report: got cv_seen=%b freq=%0d, expected 0 25", seen_valid, FREQ_COUNT);
        end
        ENABLE = 1'b1;
        wait_valid(200, n, ok);
        // 100 cycles after the edge that samples ENABLE=1.
        n_tests++;
        if (!ok || n != 101 || {FREQ_COUNT, LOCK} !== {16'd25, 1'b0}) begin
            n_fail++;
            $display("FAIL reenable_report: got ok=%b cycles=%0d freq=%0d lock=%b, expected 101 25 0",
                     ok, n, FREQ_COUNT, LOCK);
        end
    endtask

    // Reset lands on the window-end edge and must suppress that report.
    task automatic test_reset_mid();
        int n;
        bit ok;
        bit locked;
        locked = 1'b0;
        for (int k = 0; k < 6 && !locked; k++) begin
            wait_valid(150, n, ok);
            if (ok && LOCK) locked = 1'b1;
        end
        n_tests++;
        if (!locked) begin
            n_fail++;
            $display("FAIL rst_prelock: got lock=%b, expected 1", LOCK);
        end
        tick(99);
        M2F_RESET_N = 1'b0;
        tick(1);
        n_tests++;
        if ({LOCK, COUNT_VALID, ERR_HIGH, ERR_LOW, FREQ_COUNT} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got lock=%b cv=%b eh=%b el=%b freq=%0d, expected all 0",
                     LOCK, COUNT_VALID, ERR_HIGH, ERR_LOW, FREQ_COUNT);
        end
        M2F_RESET_N = 1'b1;
        wait_valid(300, n, ok);
        n_tests++;
        if (!ok || n != 101 || LOCK !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_first_report: got ok=%b cycles=%0d lock=%b, expected 101 0", ok, n, LOCK);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lost_lock();
        test_dead_and_fast();
        test_boundary_edge();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
